// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC Wishbone bus masters: bus widths, the
// default timeout error word and the bridge FSM state type.
package soc_bus_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam logic [WB_DAT_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_DRAIN = 2'd2
    } bridge_state_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating cycle counter with synchronous clear and enable; o_tc flags
// that the count sits at LIMIT.
module wb_timeout_ctr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LIMIT = 15
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != LIMIT_V)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_tc = (r_count == LIMIT_V);

endmodule

// File: rtl/cpu_wb_bridge.sv
// CPU valid/ready port to single-outstanding Wishbone B4 classic master,
// with ACK timeout and a post-cycle window that swallows trailing ACKs.
module cpu_wb_bridge
    import soc_bus_pkg::*;
#(
    parameter int unsigned          TIMEOUT      = 16,
    parameter int unsigned          DRAIN_CYCLES = 2,
    parameter logic [WB_DAT_W-1:0]  ERR_DATA     = ERR_DATA_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 mem_valid,
    input  logic [WB_ADR_W-1:0]  mem_addr,
    input  logic [WB_DAT_W-1:0]  mem_wdata,
    input  logic [WB_SEL_W-1:0]  mem_wstrb,
    output logic                 mem_ready,
    output logic [WB_DAT_W-1:0]  mem_rdata,
    output logic                 mem_err,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [WB_SEL_W-1:0]  wbm_sel_o,
    output logic [WB_ADR_W-1:0]  wbm_adr_o,
    output logic [WB_DAT_W-1:0]  wbm_dat_o,
    input  logic [WB_DAT_W-1:0]  wbm_dat_i,
    input  logic                 wbm_ack_i
);

    localparam logic [2:0] DRAIN_LOAD =
        (DRAIN_CYCLES == 0) ? 3'd0 : 3'(DRAIN_CYCLES - 1);

    bridge_state_t r_state, w_next_state;

    logic                r_cyc, r_stb, r_we, r_mem_ready, r_mem_err;
    logic [WB_SEL_W-1:0] r_sel;
    logic [WB_ADR_W-1:0] r_adr;
    logic [WB_DAT_W-1:0] r_dat_o, r_rdata;
    logic [2:0]          r_drain_cnt;

    logic w_accept, w_done_ack, w_done_to, w_tc;

    // Terminal count is raised during the TIMEOUT-th cycle of CYC.
    wb_timeout_ctr #(
        .WIDTH (8),
        .LIMIT (TIMEOUT - 1)
    ) u_timeout_ctr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_clr   (r_state != ST_BUS),
        .i_en    ((r_state == ST_BUS) && !wbm_ack_i),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The CPU still holds mem_valid during its mem_ready cycle; ignore it then.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_done_ack   = 1'b0;
        w_done_to    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_valid && !r_mem_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_BUS;
                end
            end
            ST_BUS: begin
                if (wbm_ack_i) begin
                    w_done_ack   = 1'b1;
                    w_next_state = (DRAIN_CYCLES == 0) ? ST_IDLE : ST_DRAIN;
                end else if (w_tc) begin
                    w_done_to    = 1'b1;
                    w_next_state = (DRAIN_CYCLES == 0) ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == 3'd0) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat_o     <= '0;
            r_rdata     <= '0;
            r_mem_ready <= 1'b0;
            r_mem_err   <= 1'b0;
            r_drain_cnt <= 3'd0;
        end else begin
            r_mem_ready <= w_done_ack | w_done_to;
            r_mem_err   <= w_done_to;
            if (w_accept) begin
                r_cyc   <= 1'b1;
                r_stb   <= 1'b1;
                r_adr   <= mem_addr;
                r_dat_o <= mem_wdata;
                r_we    <= (mem_wstrb != '0);
                r_sel   <= (mem_wstrb != '0) ? mem_wstrb : {WB_SEL_W{1'b1}};
            end
            if (w_done_ack) begin
                r_cyc   <= 1'b0;
                r_stb   <= 1'b0;
                r_rdata <= wbm_dat_i;
            end
            if (w_done_to) begin
                r_cyc   <= 1'b0;
                r_stb   <= 1'b0;
                r_rdata <= ERR_DATA;
            end
            if (w_done_ack || w_done_to) begin
                r_drain_cnt <= DRAIN_LOAD;
            end else if ((r_state == ST_DRAIN) && (r_drain_cnt != 3'd0)) begin
                r_drain_cnt <= r_drain_cnt - 3'd1;
            end
        end
    end

    assign mem_ready = r_mem_ready;
    assign mem_rdata = r_rdata;
    assign mem_err   = r_mem_err;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat_o;

endmodule
